// File: rtl/anim_sequencer.sv
// anim_sequencer: animation index, frame-period and frame-counter controller for the seg7 datapath.
// Arbitrates button commands against autoplay and routes every animation change through SWITCH.
module anim_sequencer #(
    parameter int NUM_ANI     = 12,
    parameter int PERIOD_W    = 24,
    parameter int PERIOD_DEF  = 10_000_000,
    parameter int PERIOD_STEP = 1_000_000,
    parameter int PERIOD_MIN  = 1_000_000,
    parameter int PERIOD_MAX  = 20_000_000,
    parameter int AUTO_LOOPS  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ena,
    input  logic                cmd_next,
    input  logic                cmd_prev,
    input  logic                cmd_faster,
    input  logic                cmd_slower,
    input  logic                cmd_pause,
    input  logic                auto_en,
    input  logic [4:0]          frame_limit,
    output logic [3:0]          animation,
    output logic [4:0]          frame,
    output logic [PERIOD_W-1:0] period,
    output logic                frame_tick,
    output logic                ani_changed,
    output logic                paused
);
    localparam int LOOP_W = (AUTO_LOOPS > 1) ? $clog2(AUTO_LOOPS) : 1;
    localparam logic [3:0]          ANI_LAST  = 4'(NUM_ANI - 1);
    localparam logic [LOOP_W-1:0]   LOOP_LAST = LOOP_W'(AUTO_LOOPS - 1);
    localparam logic [PERIOD_W:0]   STEP_X    = (PERIOD_W + 1)'(PERIOD_STEP);
    localparam logic [PERIOD_W:0]   MIN_X     = (PERIOD_W + 1)'(PERIOD_MIN);
    localparam logic [PERIOD_W:0]   MAX_X     = (PERIOD_W + 1)'(PERIOD_MAX);
    localparam logic [PERIOD_W-1:0] DEF_P     = PERIOD_W'(PERIOD_DEF);

    typedef enum logic [1:0] {RUN, PAUSED, SWITCH} state_t;

    state_t              state, state_nx;
    logic                ret_paused, ret_nx;
    logic [PERIOD_W-1:0] tick_cnt, tick_nx, period_nx, p_fast, p_slow;
    logic [PERIOD_W:0]   p_ext;
    logic [LOOP_W-1:0]   loop_cnt, loop_nx;
    logic [3:0]          ani_nx;
    logic [4:0]          frame_nx;
    logic                tick_ev, wrap, auto_req, accept, man_next, man_prev, go_next, ani_go;
    logic                spd_go, pause_go, frame_tick_nx, ani_changed_nx, paused_nx;

    always_comb begin
        accept   = state != SWITCH;
        tick_ev  = state == RUN && tick_cnt == period - PERIOD_W'(1);
        wrap     = tick_ev && frame >= frame_limit;
        auto_req = wrap && auto_en && loop_cnt == LOOP_LAST;
        man_next = accept && cmd_next && !cmd_prev;
        man_prev = accept && cmd_prev && !cmd_next;
        // a manual command always overrides (and discards) the autoplay request
        go_next  = man_next || (auto_req && !man_prev);
        ani_go   = go_next || man_prev;
        spd_go   = accept && (cmd_faster ^ cmd_slower);
        pause_go = accept && cmd_pause && !ani_go;
        p_ext    = {1'b0, period};
        p_fast   = (p_ext < MIN_X + STEP_X) ? PERIOD_W'(PERIOD_MIN) : PERIOD_W'(p_ext - STEP_X);
        p_slow   = (p_ext + STEP_X > MAX_X) ? PERIOD_W'(PERIOD_MAX) : PERIOD_W'(p_ext + STEP_X);
        state_nx = state;
        ret_nx   = ret_paused;
        ani_nx   = animation;
        frame_nx = frame;
        period_nx = period;
        tick_nx  = tick_cnt;
        loop_nx  = loop_cnt;
        if (ena) begin
            if (state == RUN)
                tick_nx = tick_ev ? '0 : tick_cnt + PERIOD_W'(1);
            if (tick_ev) begin
                frame_nx = wrap ? '0 : frame + 5'd1;
                loop_nx  = !wrap ? loop_cnt : (loop_cnt == LOOP_LAST) ? '0 : loop_cnt + LOOP_W'(1);
            end
            if (spd_go) begin
                period_nx = cmd_faster ? p_fast : p_slow;
                tick_nx   = '0;
            end
            if (state == SWITCH) begin
                state_nx = ret_paused ? PAUSED : RUN;
            end else if (ani_go) begin
                ani_nx   = go_next ? ((animation == ANI_LAST) ? '0 : animation + 4'd1)
                                   : ((animation == 4'd0) ? ANI_LAST : animation - 4'd1);
                frame_nx = '0;
                tick_nx  = '0;
                loop_nx  = '0;
                state_nx = SWITCH;
                ret_nx   = state == PAUSED;
            end else if (pause_go) begin
                state_nx = (state == RUN) ? PAUSED : RUN;
            end
        end
        frame_tick_nx  = ena && tick_ev;
        ani_changed_nx = ena && ani_go;
        // a SWITCH taken from PAUSED keeps reporting paused
        paused_nx = ena ? (state_nx == PAUSED || (state_nx == SWITCH && ret_nx)) : paused;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            ret_paused  <= 1'b0;
            animation   <= '0;
            frame       <= '0;
            period      <= DEF_P;
            tick_cnt    <= '0;
            loop_cnt    <= '0;
            frame_tick  <= 1'b0;
            ani_changed <= 1'b0;
            paused      <= 1'b0;
        end else begin
            state       <= state_nx;
            ret_paused  <= ret_nx;
            animation   <= ani_nx;
            frame       <= frame_nx;
            period      <= period_nx;
            tick_cnt    <= tick_nx;
            loop_cnt    <= loop_nx;
            frame_tick  <= frame_tick_nx;
            ani_changed <= ani_changed_nx;
            paused      <= paused_nx;
        end
    end
endmodule

// File: tb/tb_anim_sequencer.sv
// tb_anim_sequencer: table and sequence driven bench; expectations queued at drive time, compared after each edge.
module tb_anim_sequencer;
    localparam logic [5:0] C_RST = 6'b100000;
    localparam logic [5:0] C_NX  = 6'b010000;
    localparam logic [5:0] C_PV  = 6'b001000;
    localparam logic [5:0] C_FA  = 6'b000100;
    localparam logic [5:0] C_SL  = 6'b000010;
    localparam logic [5:0] C_PA  = 6'b000001;

    typedef struct packed {
        logic [5:0]  cmd;
        logic [3:0]  a;
        logic [4:0]  f;
        logic [23:0] p;
        logic        t, c, z;
    } vec_t;

    typedef struct packed {
        logic [15:0] id;
        logic [3:0]  a;
        logic [4:0]  f;
        logic [23:0] p;
        logic        t, c, z;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1, ena = 1'b1, cmd_next = 1'b0, cmd_prev = 1'b0;
    logic        cmd_faster = 1'b0, cmd_slower = 1'b0, cmd_pause = 1'b0, auto_en = 1'b0;
    logic [4:0]  frame_limit = 5'd3;
    logic [3:0]  animation;
    logic [4:0]  frame;
    logic [23:0] period;
    logic        frame_tick, ani_changed, paused;

    logic        lv_ena = 1'b1, lv_auto = 1'b0;
    logic [4:0]  lv_lim = 5'd3;
    int          checks = 0, failures = 0, sid = 0;
    exp_t        sb[$];
    exp_t        e;
    vec_t        tbl [0:26];

    anim_sequencer #(
        .NUM_ANI(12), .PERIOD_W(24), .PERIOD_DEF(10), .PERIOD_STEP(2),
        .PERIOD_MIN(2), .PERIOD_MAX(14), .AUTO_LOOPS(2)
    ) dut (
        .clk(clk), .reset(reset), .ena(ena), .cmd_next(cmd_next), .cmd_prev(cmd_prev),
        .cmd_faster(cmd_faster), .cmd_slower(cmd_slower), .cmd_pause(cmd_pause),
        .auto_en(auto_en), .frame_limit(frame_limit), .animation(animation), .frame(frame),
        .period(period), .frame_tick(frame_tick), .ani_changed(ani_changed), .paused(paused)
    );

    always #5 clk = ~clk;

    task automatic chk(input int id, input string fld, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL step %0d %s got=%0d exp=%0d", id, fld, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(int'(e.id), "animation", 24'(animation), 24'(e.a));
            chk(int'(e.id), "frame", 24'(frame), 24'(e.f));
            chk(int'(e.id), "period", period, e.p);
            chk(int'(e.id), "frame_tick", 24'(frame_tick), 24'(e.t));
            chk(int'(e.id), "ani_changed", 24'(ani_changed), 24'(e.c));
            chk(int'(e.id), "paused", 24'(paused), 24'(e.z));
        end
    end

    task automatic step(input logic [5:0] cmd, input logic [3:0] a, input logic [4:0] f,
                        input logic [23:0] p, input logic t, input logic c, input logic z);
        @(negedge clk);
        {reset, cmd_next, cmd_prev, cmd_faster, cmd_slower, cmd_pause} = cmd;
        ena = lv_ena;
        auto_en = lv_auto;
        frame_limit = lv_lim;
        sb.push_back('{id: 16'(sid), a: a, f: f, p: p, t: t, c: c, z: z});
        sid++;
    endtask

    initial begin
        tbl[0]  = '{C_PV,        4'd11, 5'd0, 24'd10, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{6'd0,        4'd11, 5'd0, 24'd10, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{6'd0,        4'd11, 5'd0, 24'd10, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{C_NX,        4'd0,  5'd0, 24'd10, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{6'd0,        4'd0,  5'd0, 24'd10, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{6'd0,        4'd0,  5'd0, 24'd10, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{C_PV,        4'd11, 5'd0, 24'd10, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{6'd0,        4'd11, 5'd0, 24'd10, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{6'd0,        4'd11, 5'd0, 24'd10, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{C_NX | C_PV, 4'd11, 5'd0, 24'd10, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{6'd0,        4'd11, 5'd0, 24'd10, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{C_FA,        4'd11, 5'd0, 24'd8,  1'b0, 1'b0, 1'b0};
        tbl[12] = '{C_FA,        4'd11, 5'd0, 24'd6,  1'b0, 1'b0, 1'b0};
        tbl[13] = '{C_FA,        4'd11, 5'd0, 24'd4,  1'b0, 1'b0, 1'b0};
        tbl[14] = '{C_FA,        4'd11, 5'd0, 24'd2,  1'b0, 1'b0, 1'b0};
        tbl[15] = '{C_FA,        4'd11, 5'd0, 24'd2,  1'b0, 1'b0, 1'b0};
        tbl[16] = '{C_SL,        4'd11, 5'd0, 24'd4,  1'b0, 1'b0, 1'b0};
        tbl[17] = '{C_SL,        4'd11, 5'd0, 24'd6,  1'b0, 1'b0, 1'b0};
        tbl[18] = '{C_SL,        4'd11, 5'd0, 24'd8,  1'b0, 1'b0, 1'b0};
        tbl[19] = '{C_SL,        4'd11, 5'd0, 24'd10, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{C_SL,        4'd11, 5'd0, 24'd12, 1'b0, 1'b0, 1'b0};
        tbl[21] = '{C_SL,        4'd11, 5'd0, 24'd14, 1'b0, 1'b0, 1'b0};
        tbl[22] = '{C_SL,        4'd11, 5'd0, 24'd14, 1'b0, 1'b0, 1'b0};
        tbl[23] = '{C_FA | C_SL, 4'd11, 5'd0, 24'd14, 1'b0, 1'b0, 1'b0};
        tbl[24] = '{6'd0,        4'd11, 5'd0, 24'd14, 1'b0, 1'b0, 1'b0};
        tbl[25] = '{C_FA,        4'd11, 5'd0, 24'd12, 1'b0, 1'b0, 1'b0};
        tbl[26] = '{C_FA,        4'd11, 5'd0, 24'd10, 1'b0, 1'b0, 1'b0};

        // reset and free-running frames with limit 3
        step(C_RST, 4'd0, 5'd0, 24'd10, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 45; k++)
            step(6'd0, 4'd0, 5'((k / 10) % 4), 24'd10, k % 10 == 0, 1'b0, 1'b0);

        // animation wrap, cancel, and period saturation
        foreach (tbl[i])
            step(tbl[i].cmd, tbl[i].a, tbl[i].f, tbl[i].p, tbl[i].t, tbl[i].c, tbl[i].z);

        // autoplay after two loops, then first tick period+1 after the change
        lv_lim = 5'd1;
        lv_auto = 1'b1;
        for (int k = 1; k <= 51; k++) begin
            if (k < 40)
                step(6'd0, 4'd11, 5'((k / 10) % 2), 24'd10, k % 10 == 0, 1'b0, 1'b0);
            else
                step(6'd0, 4'd0, (k == 51) ? 5'd1 : 5'd0, 24'd10, k == 40 || k == 51, k == 40, 1'b0);
        end
        lv_auto = 1'b0;
        for (int k = 52; k <= 111; k++)
            step(6'd0, 4'd0, 5'(((k - 41) / 10) % 2), 24'd10, (k - 51) % 10 == 0, 1'b0, 1'b0);

        // pause holds tick_cnt and frame; next while paused stays paused
        lv_lim = 5'd3;
        step(C_RST, 4'd0, 5'd0, 24'd10, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 5; j++) step(6'd0, 4'd0, 5'd0, 24'd10, 1'b0, 1'b0, 1'b0);
        step(C_PA, 4'd0, 5'd0, 24'd10, 1'b0, 1'b0, 1'b1);
        for (int j = 1; j <= 50; j++) step(6'd0, 4'd0, 5'd0, 24'd10, 1'b0, 1'b0, 1'b1);
        step(C_PA, 4'd0, 5'd0, 24'd10, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 4; j++)
            step(6'd0, 4'd0, (j == 4) ? 5'd1 : 5'd0, 24'd10, j == 4, 1'b0, 1'b0);
        step(C_PA, 4'd0, 5'd1, 24'd10, 1'b0, 1'b0, 1'b1);
        for (int j = 1; j <= 5; j++) step(6'd0, 4'd0, 5'd1, 24'd10, 1'b0, 1'b0, 1'b1);
        step(C_NX, 4'd1, 5'd0, 24'd10, 1'b0, 1'b1, 1'b1);
        step(6'd0, 4'd1, 5'd0, 24'd10, 1'b0, 1'b0, 1'b1);
        step(6'd0, 4'd1, 5'd0, 24'd10, 1'b0, 1'b0, 1'b1);
        step(C_PA, 4'd1, 5'd0, 24'd10, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 10; j++)
            step(6'd0, 4'd1, (j == 10) ? 5'd1 : 5'd0, 24'd10, j == 10, 1'b0, 1'b0);

        // SWITCH drops commands; reset during SWITCH; ena=0 freezes everything
        step(C_FA, 4'd1, 5'd1, 24'd8, 1'b0, 1'b0, 1'b0);
        step(C_NX, 4'd2, 5'd0, 24'd8, 1'b0, 1'b1, 1'b0);
        step(C_NX, 4'd2, 5'd0, 24'd8, 1'b0, 1'b0, 1'b0);
        step(6'd0, 4'd2, 5'd0, 24'd8, 1'b0, 1'b0, 1'b0);
        step(C_NX, 4'd3, 5'd0, 24'd8, 1'b0, 1'b1, 1'b0);
        step(C_RST, 4'd0, 5'd0, 24'd10, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 10; j++)
            step(6'd0, 4'd0, (j == 10) ? 5'd1 : 5'd0, 24'd10, j == 10, 1'b0, 1'b0);
        lv_ena = 1'b0;
        step(C_NX, 4'd0, 5'd1, 24'd10, 1'b0, 1'b0, 1'b0);
        step(C_PA, 4'd0, 5'd1, 24'd10, 1'b0, 1'b0, 1'b0);
        step(C_FA, 4'd0, 5'd1, 24'd10, 1'b0, 1'b0, 1'b0);
        for (int j = 1; j <= 12; j++) step(6'd0, 4'd0, 5'd1, 24'd10, 1'b0, 1'b0, 1'b0);
        lv_ena = 1'b1;
        for (int j = 1; j <= 10; j++)
            step(6'd0, 4'd0, (j == 10) ? 5'd2 : 5'd1, 24'd10, j == 10, 1'b0, 1'b0);

        @(negedge clk);
        {reset, cmd_next, cmd_prev, cmd_faster, cmd_slower, cmd_pause} = 6'd0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
